cache_fill_ctrl: RTL and testbench

- Miss-handling controller for the 2-way, 64-set I-cache and D-cache.
- Arbitrates I-cache and D-cache misses onto the single pipelined main memory, then picks a victim way from the set's metadata bytes.
- Fetches the 8-word block, streams each word into the selected data array, and finally rewrites both ways' metadata (tag/valid/LRU) in two sequential cycles.
- Sits between both caches' tag/data arrays and the memory model, and drives the pipeline stall signals.

---
 rtl/cache_pkg.sv | 23 ++
 rtl/victim_sel.sv | 21 ++
 rtl/cache_fill_ctrl.sv | 171 +++++++++++++++++
 tb/tb_cache_fill_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and field positions for the I/D-cache miss-fill controller.
package cache_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_META_NEW,
        S_META_OTHER,
        S_DONE
    } state_t;

    localparam int VALID_BIT       = 7;
    localparam int LRU_BIT         = 6;
    localparam int TAG_W           = 6;
    localparam int TAG_LSB         = 10;
    localparam int INDEX_MSB       = 9;
    localparam int INDEX_LSB       = 4;
    localparam int WORD_LSB        = 1;
    localparam int WORDS_PER_BLOCK = 8;

    localparam logic [15:0] BLOCK_MASK = 16'hFFF0;

endpackage

// File: rtl/victim_sel.sv
// Victim way choice from each way's {valid, lru} flag pair: fill an invalid way
// first, otherwise evict the way whose LRU bit marks it as next to go.
module victim_sel (
    input  logic [1:0] flags0,
    input  logic [1:0] flags1,
    output logic       way
);

    always_comb begin
        way = 1'b0;
        if (!flags0[1])
            way = 1'b0;
        else if (!flags1[1])
            way = 1'b1;
        else if (flags1[0] && !flags0[0])
            way = 1'b1;
        else
            way = 1'b0;
    end

endmodule

// File: rtl/cache_fill_ctrl.sv
// Miss-fill controller: arbitrates I/D misses, fetches an 8-word block from pipelined
// memory, then rewrites both ways' metadata. Define ROUND_ROBIN_ARB_EN for alternating priority.
module cache_fill_ctrl
    import cache_pkg::*;
#(
    parameter int MEM_LATENCY = 4,
    parameter int WORDS       = WORDS_PER_BLOCK
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_miss,
    input  logic [15:0]                i_addr,
    input  logic                       d_miss,
    input  logic [15:0]                d_addr,
    input  logic [7:0]                 meta0,
    input  logic [7:0]                 meta1,
    input  logic [15:0]                mem_data_out,
    input  logic                       mem_data_valid,
    output logic                       mem_enable,
    output logic [15:0]                mem_addr,
    output logic                       fill_sel,
    output logic [5:0]                 meta_set,
    output logic                       fill_we,
    output logic                       fill_way,
    output logic [$clog2(WORDS)-1:0]   fill_word,
    output logic [15:0]                fill_data,
    output logic                       meta_write0,
    output logic                       meta_write1,
    output logic [7:0]                 meta_din,
    output logic                       i_stall,
    output logic                       d_stall,
    output logic                       i_done,
    output logic                       d_done
);

    localparam int CW = $clog2(WORDS);

    generate
        if (MEM_LATENCY < 1) begin : g_bad_latency
            $error("cache_fill_ctrl: MEM_LATENCY must be at least 1");
        end
    endgenerate

    state_t        state, next_state;
    logic          sel_q;
    logic [15:0]   base_q;
    logic [5:0]    set_q;
    logic          victim_q;
    logic [7:0]    meta0_q, meta1_q;
    logic [CW:0]   iss_cnt;
    logic [CW-1:0] ret_cnt;

    logic          win_d;
    logic [15:0]   win_addr;
    logic          victim;
    logic          miss_any;

`ifdef ROUND_ROBIN_ARB_EN
    logic prio_d;
    assign win_d = d_miss & (prio_d | ~i_miss);
`else
    assign win_d = d_miss;
`endif

    assign win_addr = win_d ? d_addr : i_addr;
    assign miss_any = i_miss | d_miss;

    victim_sel u_victim_sel (
        .flags0 ({meta0[VALID_BIT], meta0[LRU_BIT]}),
        .flags1 ({meta1[VALID_BIT], meta1[LRU_BIT]}),
        .way    (victim)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            sel_q    <= 1'b0;
            base_q   <= '0;
            set_q    <= '0;
            victim_q <= 1'b0;
            meta0_q  <= '0;
            meta1_q  <= '0;
            iss_cnt  <= '0;
            ret_cnt  <= '0;
`ifdef ROUND_ROBIN_ARB_EN
            prio_d   <= 1'b1;
`endif
        end else begin
            state <= next_state;
            case (state)
                S_IDLE: begin
                    if (miss_any) begin
                        sel_q    <= win_d;
                        base_q   <= win_addr & BLOCK_MASK;
                        set_q    <= win_addr[INDEX_MSB:INDEX_LSB];
                        victim_q <= victim;
                        meta0_q  <= meta0;
                        meta1_q  <= meta1;
                        iss_cnt  <= '0;
                        ret_cnt  <= '0;
                    end
                end
                S_FILL: begin
                    if (!iss_cnt[CW])
                        iss_cnt <= iss_cnt + 1'b1;
                    if (mem_data_valid)
                        ret_cnt <= ret_cnt + 1'b1;
                end
`ifdef ROUND_ROBIN_ARB_EN
                S_DONE: prio_d <= ~sel_q;
`endif
                default: ;
            endcase
        end
    end

    // In IDLE, fill_sel/meta_set follow the current winner so the selected cache
    // presents the right metadata bytes before the miss is captured.
    always_comb begin
        next_state  = state;
        mem_enable  = 1'b0;
        fill_we     = 1'b0;
        meta_write0 = 1'b0;
        meta_write1 = 1'b0;
        meta_din    = '0;
        i_done      = 1'b0;
        d_done      = 1'b0;
        mem_addr    = base_q | (16'(iss_cnt[CW-1:0]) << WORD_LSB);
        fill_sel    = (state == S_IDLE) ? win_d : sel_q;
        meta_set    = (state == S_IDLE) ? win_addr[INDEX_MSB:INDEX_LSB] : set_q;
        fill_way    = victim_q;
        fill_word   = ret_cnt;
        fill_data   = mem_data_out;

        case (state)
            S_IDLE: begin
                if (miss_any)
                    next_state = S_FILL;
            end
            S_FILL: begin
                mem_enable = ~iss_cnt[CW];
                fill_we    = mem_data_valid;
                if (mem_data_valid && ret_cnt == CW'(WORDS - 1))
                    next_state = S_META_NEW;
            end
            S_META_NEW: begin
                meta_din    = {1'b1, 1'b0, base_q[TAG_LSB +: TAG_W]};
                meta_write0 = ~victim_q;
                meta_write1 = victim_q;
                next_state  = S_META_OTHER;
            end
            S_META_OTHER: begin
                meta_din          = victim_q ? meta0_q : meta1_q;
                meta_din[LRU_BIT] = 1'b1;
                meta_write0       = victim_q;
                meta_write1       = ~victim_q;
                next_state        = S_DONE;
            end
            S_DONE: begin
                i_done     = ~sel_q;
                d_done     = sel_q;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    assign i_stall = i_miss & ~i_done;
    assign d_stall = d_miss & ~d_done;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl with a 4-cycle pipelined memory model.
module tb_cache_fill_ctrl;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst, i_miss, d_miss;
    logic [15:0] i_addr, d_addr;
    logic [7:0]  meta0, meta1;
    logic [15:0] mem_data_out;
    logic        mem_data_valid;
    logic        mem_enable;
    logic [15:0] mem_addr;
    logic        fill_sel, fill_we, fill_way;
    logic [5:0]  meta_set;
    logic [2:0]  fill_word;
    logic [15:0] fill_data;
    logic        meta_write0, meta_write1;
    logic [7:0]  meta_din;
    logic        i_stall, d_stall, i_done, d_done;

    logic            inj_valid;
    logic [LAT-1:0]  vpipe = '0;
    logic [15:0]     dpipe [LAT];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cache_fill_ctrl #(.MEM_LATENCY(LAT), .WORDS(8)) dut (
        .clk(clk), .rst(rst), .i_miss(i_miss), .i_addr(i_addr), .d_miss(d_miss), .d_addr(d_addr),
        .meta0(meta0), .meta1(meta1), .mem_data_out(mem_data_out), .mem_data_valid(mem_data_valid),
        .mem_enable(mem_enable), .mem_addr(mem_addr), .fill_sel(fill_sel), .meta_set(meta_set),
        .fill_we(fill_we), .fill_way(fill_way), .fill_word(fill_word), .fill_data(fill_data),
        .meta_write0(meta_write0), .meta_write1(meta_write1), .meta_din(meta_din),
        .i_stall(i_stall), .d_stall(d_stall), .i_done(i_done), .d_done(d_done)
    );

    // Memory model: data word is the requested address XOR a fixed pattern.
    always @(posedge clk) begin
        vpipe    <= {vpipe[LAT-2:0], mem_enable};
        dpipe[0] <= mem_addr ^ 16'hA5A5;
        for (int k = 1; k < LAT; k++) dpipe[k] <= dpipe[k-1];
    end
    assign mem_data_valid = vpipe[LAT-1] | inj_valid;
    assign mem_data_out   = inj_valid ? 16'hDEAD : dpipe[LAT-1];

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; i_miss = 1'b0; d_miss = 1'b0; inj_valid = 1'b0;
        i_addr = '0; d_addr = '0; meta0 = '0; meta1 = '0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if ({mem_enable, fill_we, meta_write0, meta_write1, i_done, d_done, i_stall, d_stall} !== 8'h00) begin
            n_bad++; $display("FAIL reset.strobes got %b exp 00000000",
                {mem_enable, fill_we, meta_write0, meta_write1, i_done, d_done, i_stall, d_stall});
        end
        n_cmp++;
        if ({fill_sel, meta_set, fill_way, fill_word, mem_addr, meta_din} !== 35'd0) begin
            n_bad++; $display("FAIL reset.regs got sel=%b set=%h way=%b word=%h addr=%h din=%h exp all 0",
                fill_sel, meta_set, fill_way, fill_word, mem_addr, meta_din);
        end
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_d_fill;
        logic exp_en, exp_we;
        d_addr = 16'h1234; meta0 = 8'h00; meta1 = 8'h00; d_miss = 1'b1;
        for (int c = 0; c <= 16; c++) begin
            if (c == 16) d_miss = 1'b0;
            @(negedge clk);
            exp_en = (c >= 1 && c <= 8);
            exp_we = (c >= 5 && c <= 12);
            n_cmp++;
            if (mem_enable !== exp_en) begin
                n_bad++; $display("FAIL d_fill.mem_enable c=%0d got %b exp %b", c, mem_enable, exp_en);
            end
            if (exp_en) begin
                n_cmp++;
                if (mem_addr !== 16'h1230 + 16'(2 * (c - 1))) begin
                    n_bad++; $display("FAIL d_fill.mem_addr c=%0d got %h exp %h", c, mem_addr, 16'h1230 + 16'(2 * (c - 1)));
                end
            end
            n_cmp++;
            if (fill_we !== exp_we) begin
                n_bad++; $display("FAIL d_fill.fill_we c=%0d got %b exp %b", c, fill_we, exp_we);
            end
            if (exp_we) begin
                n_cmp++;
                if (fill_word !== 3'(c - 5) || fill_data !== ((16'h1230 + 16'(2 * (c - 5))) ^ 16'hA5A5)) begin
                    n_bad++; $display("FAIL d_fill.word c=%0d got %0d/%h exp %0d/%h", c, fill_word, fill_data,
                        c - 5, (16'h1230 + 16'(2 * (c - 5))) ^ 16'hA5A5);
                end
            end
            n_cmp++;
            if (meta_write0 !== (c == 13) || meta_write1 !== (c == 14)) begin
                n_bad++; $display("FAIL d_fill.meta_write c=%0d got %b%b exp %b%b", c, meta_write0, meta_write1, c == 13, c == 14);
            end
            if (c == 13 || c == 14) begin
                n_cmp++;
                if (meta_din !== ((c == 13) ? 8'h84 : 8'h40)) begin
                    n_bad++; $display("FAIL d_fill.meta_din c=%0d got %h exp %h", c, meta_din, (c == 13) ? 8'h84 : 8'h40);
                end
            end
            n_cmp++;
            if (d_done !== (c == 15) || d_stall !== (c < 15) || i_done !== 1'b0) begin
                n_bad++; $display("FAIL d_fill.done_stall c=%0d got d_done=%b d_stall=%b i_done=%b exp %b %b 0",
                    c, d_done, d_stall, i_done, c == 15, c < 15);
            end
            if (c <= 15) begin
                n_cmp++;
                if (meta_set !== 6'h23 || fill_sel !== 1'b1 || (c >= 1 && fill_way !== 1'b0)) begin
                    n_bad++; $display("FAIL d_fill.target c=%0d got set=%h sel=%b way=%b exp 23 1 0", c, meta_set, fill_sel, fill_way);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_simultaneous;
        i_addr = 16'h0A50; d_addr = 16'h1234; meta0 = 8'h00; meta1 = 8'h00;
        i_miss = 1'b1; d_miss = 1'b1;
        for (int c = 0; c <= 31; c++) begin
            if (c == 16) d_miss = 1'b0;
            @(negedge clk);
            if (c <= 15) begin
                n_cmp++;
                if (i_stall !== 1'b1 || fill_sel !== 1'b1) begin
                    n_bad++; $display("FAIL simul.d_first c=%0d got i_stall=%b sel=%b exp 1 1", c, i_stall, fill_sel);
                end
            end
            if (c == 15 || c == 31) begin
                n_cmp++;
                if (d_done !== (c == 15) || i_done !== (c == 31)) begin
                    n_bad++; $display("FAIL simul.done c=%0d got d=%b i=%b exp %b %b", c, d_done, i_done, c == 15, c == 31);
                end
            end
            if (c == 16) begin
                n_cmp++;
                if (fill_sel !== 1'b0 || meta_set !== 6'h25) begin
                    n_bad++; $display("FAIL simul.i_accept got sel=%b set=%h exp 0 25", fill_sel, meta_set);
                end
            end
            if (c == 17) begin
                n_cmp++;
                if (mem_enable !== 1'b1 || mem_addr !== 16'h0A50) begin
                    n_bad++; $display("FAIL simul.i_issue got en=%b addr=%h exp 1 0a50", mem_enable, mem_addr);
                end
            end
            next_cycle();
        end
        i_miss = 1'b0;
        next_cycle();
    endtask

    task automatic test_victim;
        logic [7:0] tm0 [3] = '{8'hC5, 8'h85, 8'h85};
        logic [7:0] tm1 [3] = '{8'h85, 8'hC5, 8'h00};
        logic       tway[3] = '{1'b0, 1'b1, 1'b1};
        logic [7:0] toth[3] = '{8'hC5, 8'hC5, 8'hC5};
        for (int v = 0; v < 3; v++) begin
            d_addr = 16'h4C40; meta0 = tm0[v]; meta1 = tm1[v]; d_miss = 1'b1;
            for (int c = 0; c <= 16; c++) begin
                if (c == 16) d_miss = 1'b0;
                @(negedge clk);
                if (c == 1) begin
                    n_cmp++;
                    if (fill_way !== tway[v]) begin
                        n_bad++; $display("FAIL victim.way v=%0d got %b exp %b", v, fill_way, tway[v]);
                    end
                end
                if (c == 13) begin
                    n_cmp++;
                    if (meta_write0 !== ~tway[v] || meta_write1 !== tway[v] || meta_din !== 8'h93) begin
                        n_bad++; $display("FAIL victim.meta_new v=%0d got %b%b %h exp %b%b 93",
                            v, meta_write0, meta_write1, meta_din, ~tway[v], tway[v]);
                    end
                end
                if (c == 14) begin
                    n_cmp++;
                    if (meta_write0 !== tway[v] || meta_write1 !== ~tway[v] || meta_din !== toth[v]) begin
                        n_bad++; $display("FAIL victim.meta_other v=%0d got %b%b %h exp %b%b %h",
                            v, meta_write0, meta_write1, meta_din, tway[v], ~tway[v], toth[v]);
                    end
                end
                next_cycle();
            end
        end
    endtask

    task automatic test_reset_mid_fill;
        i_addr = 16'h0000; d_addr = 16'h4560; meta0 = 8'h85; meta1 = 8'h00; d_miss = 1'b1;
        for (int c = 0; c <= 20; c++) begin
            if (c == 7) begin rst = 1'b1; d_miss = 1'b0; end
            if (c == 8) rst = 1'b0;
            inj_valid = (c >= 12 && c <= 15);
            @(negedge clk);
            if (c == 6) begin
                n_cmp++;
                if (fill_we !== 1'b1) begin
                    n_bad++; $display("FAIL rst_mid.partial got fill_we=%b exp 1", fill_we);
                end
            end
            if (c >= 8) begin
                n_cmp++;
                if ({mem_enable, fill_we, meta_write0, meta_write1, d_done, i_done} !== 6'b0) begin
                    n_bad++; $display("FAIL rst_mid.quiet c=%0d got %b exp 000000", c,
                        {mem_enable, fill_we, meta_write0, meta_write1, d_done, i_done});
                end
            end
            if (c == 8 || c == 15) begin
                n_cmp++;
                if ({fill_sel, meta_set, fill_way, fill_word, mem_addr} !== 27'd0) begin
                    n_bad++; $display("FAIL rst_mid.regs c=%0d got sel=%b set=%h way=%b word=%h addr=%h exp all 0",
                        c, fill_sel, meta_set, fill_way, fill_word, mem_addr);
                end
            end
            next_cycle();
        end
        inj_valid = 1'b0;
    endtask

    task automatic test_miss_drop;
        d_addr = 16'h2E08; meta0 = 8'h00; meta1 = 8'h00; d_miss = 1'b1;
        for (int c = 0; c <= 16; c++) begin
            if (c == 3) d_miss = 1'b0;
            @(negedge clk);
            n_cmp++;
            if (d_done !== (c == 15) || d_stall !== (c < 3)) begin
                n_bad++; $display("FAIL drop.done c=%0d got done=%b stall=%b exp %b %b", c, d_done, d_stall, c == 15, c < 3);
            end
            if (c == 13) begin
                n_cmp++;
                if (meta_write0 !== 1'b1 || meta_din !== 8'h8B) begin
                    n_bad++; $display("FAIL drop.meta_new got w0=%b din=%h exp 1 8b", meta_write0, meta_din);
                end
            end
            next_cycle();
        end
    endtask

`ifdef ROUND_ROBIN_ARB_EN
    task automatic test_round_robin;
        i_addr = 16'h0A50; d_addr = 16'h1234; meta0 = 8'h00; meta1 = 8'h00;
        i_miss = 1'b1; d_miss = 1'b1;
        for (int c = 0; c <= 63; c++) begin
            @(negedge clk);
            if (c % 16 == 1) begin
                n_cmp++;
                if (fill_sel !== ((c / 16) % 2 == 0)) begin
                    n_bad++; $display("FAIL rr.order c=%0d got sel=%b exp %b", c, fill_sel, (c / 16) % 2 == 0);
                end
            end
            if (c % 16 == 15) begin
                n_cmp++;
                if (d_done !== ((c / 16) % 2 == 0) || i_done !== ((c / 16) % 2 == 1)) begin
                    n_bad++; $display("FAIL rr.done c=%0d got d=%b i=%b", c, d_done, i_done);
                end
            end
            next_cycle();
        end
        i_miss = 1'b0; d_miss = 1'b0;
        next_cycle();
    endtask
`endif

    initial begin
        test_reset();
        test_d_fill();
        test_simultaneous();
        test_victim();
        test_reset_mid_fill();
        test_miss_drop();
`ifdef ROUND_ROBIN_ARB_EN
        test_round_robin();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
